// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/DMA arbiter for the single-port byte data RAM
// Optional starvation guard: define DMEM_ARB_STARVE_GUARD_EN.
module dmem_arbiter #(
  parameter int bus_addr_data_width = 13,
  parameter int starve_max          = 15
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cpu_we,
  input  logic                           cpu_re,
  input  logic [bus_addr_data_width-1:0] cpu_a,
  input  logic [7:0]                     cpu_w,
  output logic [7:0]                     cpu_r,
  output logic                           cpu_stall,
  input  logic                           dma_req,
  input  logic                           dma_we,
  input  logic [bus_addr_data_width-1:0] dma_a,
  input  logic [7:0]                     dma_w,
  output logic [7:0]                     dma_r,
  output logic                           dma_ack,
  output logic                           dmem_we,
  output logic                           dmem_re,
  output logic [bus_addr_data_width-1:0] dmem_a,
  output logic [7:0]                     dmem_w,
  input  logic [7:0]                     dmem_r
);

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  state_t     state;
  state_t     state_next;
  logic       cpu_active;
  logic       starved;
  logic       dma_gnt;
  logic [7:0] dma_r_q;

  assign cpu_active = cpu_we | cpu_re;
  assign dma_gnt    = (state == IDLE) & dma_req & ~rst & (~cpu_active | starved);

`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam int CW = (starve_max < 1) ? 1 : $clog2(starve_max + 1);
  localparam logic [CW-1:0] STARVE_LIMIT = CW'(starve_max);

  logic [CW-1:0] starve_cnt;

  // Counts denied IDLE cycles of the current request; the ACK cycle neither counts nor clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (dma_gnt || !dma_req) begin
      starve_cnt <= '0;
    end else if (state == IDLE && starve_cnt != STARVE_LIMIT) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end

  assign starved   = (starve_cnt == STARVE_LIMIT);
  assign cpu_stall = dma_gnt & cpu_active;
`else
  assign starved   = 1'b0;
  assign cpu_stall = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (dma_gnt) state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Read data is captured at the grant edge; writes leave the last read value in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      dma_r_q <= 8'h00;
    end else if (dma_gnt && !dma_we) begin
      dma_r_q <= dmem_r;
    end
  end

  assign dma_r   = dma_r_q;
  assign dma_ack = (state == ACK);
  assign cpu_r   = dmem_r;

  // A granted DMA fully replaces the CPU access, so a stalled CPU write never reaches the RAM.
  always_comb begin
    dmem_we = cpu_we;
    dmem_re = cpu_re;
    dmem_a  = cpu_a;
    dmem_w  = cpu_w;
    if (dma_gnt) begin
      dmem_we = dma_we;
      dmem_re = ~dma_we;
      dmem_a  = dma_a;
      dmem_w  = dma_w;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter against a cycle-level reference model
module tb_dmem_arbiter;
  localparam int AW = 13;
  localparam int SM = 3;
`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_we, cpu_re;
  logic [AW-1:0] cpu_a;
  logic [7:0]    cpu_w, cpu_r;
  logic          cpu_stall;
  logic          dma_req, dma_we;
  logic [AW-1:0] dma_a;
  logic [7:0]    dma_w, dma_r;
  logic          dma_ack;
  logic          dmem_we, dmem_re;
  logic [AW-1:0] dmem_a;
  logic [7:0]    dmem_w, dmem_r;

  logic [7:0] ram     [0:(1<<AW)-1];
  logic [7:0] mdl_mem [0:(1<<AW)-1];
  bit         mdl_ack;
  int         mdl_wait;
  logic [7:0] mdl_dma_r;
  int         checks = 0;
  int         passed = 0;

  dmem_arbiter #(.bus_addr_data_width(AW), .starve_max(SM)) dut (
    .clk(clk), .rst(rst),
    .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_a(cpu_a), .cpu_w(cpu_w), .cpu_r(cpu_r), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_a(dma_a), .dma_w(dma_w), .dma_r(dma_r), .dma_ack(dma_ack),
    .dmem_we(dmem_we), .dmem_re(dmem_re), .dmem_a(dmem_a), .dmem_w(dmem_w), .dmem_r(dmem_r)
  );

  always #5 clk = ~clk;

  assign dmem_r = dmem_re ? ram[dmem_a] : 8'hzz;
  always @(posedge clk) if (dmem_we) ram[dmem_a] <= dmem_w;

  // The DMA gets the RAM unless it just finished, and only if the CPU is quiet or it has waited long enough.
  function automatic bit mdl_grant();
    return !rst && !mdl_ack && dma_req && (!(cpu_we || cpu_re) || (GUARD && mdl_wait >= SM));
  endfunction

  task automatic mdl_advance(input bit g);
    bit was_ack;
    was_ack = mdl_ack;
    if (g) begin
      if (dma_we) mdl_mem[dma_a] = dma_w;
      else mdl_dma_r = mdl_mem[dma_a];
    end else if (cpu_we) begin
      mdl_mem[cpu_a] = cpu_w;
    end
    if (rst) begin
      mdl_ack = 1'b0; mdl_wait = 0; mdl_dma_r = 8'h00;
    end else begin
      if (g || !dma_req) mdl_wait = 0;
      else if (!was_ack) mdl_wait++;
      mdl_ack = g;
    end
  endtask

  task automatic tick(input string tag);
    bit g, act, exp_we;
    logic [AW-1:0] exp_a;
    act = cpu_we | cpu_re;
    g = mdl_grant();
    exp_we = g ? dma_we : cpu_we;
    exp_a = g ? dma_a : cpu_a;
    #2;
    checks++; if (cpu_stall !== (GUARD & g & act)) $display("FAIL %s cpu_stall: got %b expected %b", tag, cpu_stall, GUARD & g & act); else passed++;
    checks++; if (dma_ack !== mdl_ack) $display("FAIL %s dma_ack: got %b expected %b", tag, dma_ack, mdl_ack); else passed++;
    checks++; if (dmem_we !== exp_we) $display("FAIL %s dmem_we: got %b expected %b", tag, dmem_we, exp_we); else passed++;
    checks++; if (dmem_a !== exp_a) $display("FAIL %s dmem_a: got %h expected %h", tag, dmem_a, exp_a); else passed++;
    if (mdl_ack) begin
      checks++; if (dma_r !== mdl_dma_r) $display("FAIL %s dma_r: got %h expected %h", tag, dma_r, mdl_dma_r); else passed++;
    end
    if (cpu_re && !g) begin
      checks++; if (cpu_r !== mdl_mem[cpu_a]) $display("FAIL %s cpu_r: got %h expected %h", tag, cpu_r, mdl_mem[cpu_a]); else passed++;
    end
    @(posedge clk);
    mdl_advance(g);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    cpu_we = 1'b0; cpu_re = 1'b0; cpu_a = '0; cpu_w = 8'h00;
    dma_req = 1'b0; dma_we = 1'b0; dma_a = '0; dma_w = 8'h00;
  endtask

  task automatic cpu_write(input logic [AW-1:0] a, input logic [7:0] w);
    idle_inputs();
    cpu_we = 1'b1; cpu_a = a; cpu_w = w;
    tick("cpu_preload");
    idle_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    cpu_re = 1'b1; cpu_a = 13'h007;
    dma_req = 1'b1; dma_we = 1'b1; dma_a = 13'h005; dma_w = 8'hEE;
    @(posedge clk); @(negedge clk);
    mdl_ack = 1'b0; mdl_wait = 0; mdl_dma_r = 8'h00;
    #1;
    checks++; if (dma_ack !== 1'b0) $display("FAIL reset dma_ack: got %b expected 0", dma_ack); else passed++;
    checks++; if (dma_r !== 8'h00) $display("FAIL reset dma_r: got %h expected 00", dma_r); else passed++;
    checks++; if (cpu_stall !== 1'b0) $display("FAIL reset cpu_stall: got %b expected 0", cpu_stall); else passed++;
    checks++; if (dmem_a !== 13'h007) $display("FAIL reset dmem_a: got %h expected 007", dmem_a); else passed++;
    checks++; if (dmem_we !== 1'b0) $display("FAIL reset dmem_we: got %b expected 0", dmem_we); else passed++;
    tick("reset_hold");
    rst = 1'b0;
    idle_inputs();
    tick("reset_release");
  endtask

  task automatic test_dma_write_read();
    dma_req = 1'b1; dma_we = 1'b1; dma_a = 13'h010; dma_w = 8'hA5;
    tick("t1_wr_grant");
    #1;
    checks++; if (dma_ack !== 1'b1) $display("FAIL t1_wr_ack: got %b expected 1", dma_ack); else passed++;
    tick("t1_wr_ack");
    idle_inputs();
    #1;
    checks++; if (dma_ack !== 1'b0) $display("FAIL t1_ack_single: got %b expected 0", dma_ack); else passed++;
    tick("t1_gap");
    dma_req = 1'b1; dma_we = 1'b0; dma_a = 13'h010;
    tick("t1_rd_grant");
    #1;
    checks++; if (dma_ack !== 1'b1) $display("FAIL t1_rd_ack: got %b expected 1", dma_ack); else passed++;
    checks++; if (dma_r !== 8'hA5) $display("FAIL t1_rd_data: got %h expected a5", dma_r); else passed++;
    tick("t1_rd_ack");
    idle_inputs();
    tick("t1_idle");
  endtask

  task automatic test_starve();
    cpu_write(13'h020, 8'h5A);
    cpu_re = 1'b1; cpu_a = 13'h020;
    dma_req = 1'b1; dma_we = 1'b0; dma_a = 13'h010;
`ifdef DMEM_ARB_STARVE_GUARD_EN
    for (int k = 1; k <= 4; k++) begin
      #1;
      checks++; if (cpu_stall !== (k == 4)) $display("FAIL t2_stall cycle %0d: got %b expected %b", k, cpu_stall, k == 4); else passed++;
      tick("t2_busy");
    end
    #1;
    checks++; if (dma_ack !== 1'b1) $display("FAIL t2_ack: got %b expected 1", dma_ack); else passed++;
    checks++; if (cpu_r !== 8'h5A) $display("FAIL t2_cpu_data: got %h expected 5a", cpu_r); else passed++;
    tick("t2_ack");
`else
    for (int k = 1; k <= 6; k++) begin
      #1;
      checks++; if (cpu_stall !== 1'b0) $display("FAIL t3_stall cycle %0d: got %b expected 0", k, cpu_stall); else passed++;
      checks++; if (dma_ack !== 1'b0) $display("FAIL t3_ack cycle %0d: got %b expected 0", k, dma_ack); else passed++;
      tick("t3_busy");
    end
    cpu_re = 1'b0;
    tick("t3_cpu_idle");
    #1;
    checks++; if (dma_ack !== 1'b1) $display("FAIL t3_ack_after_idle: got %b expected 1", dma_ack); else passed++;
    tick("t3_ack");
`endif
    idle_inputs();
    tick("t2_idle");
  endtask

  task automatic test_collision();
    cpu_re = 1'b1; cpu_a = 13'h020;
    dma_req = 1'b1; dma_we = 1'b1; dma_a = 13'h040; dma_w = 8'h44;
    for (int k = 0; k < 3; k++) tick("t4_busy");
    cpu_re = 1'b0; cpu_we = 1'b1; cpu_a = 13'h040; cpu_w = 8'h33;
`ifdef DMEM_ARB_STARVE_GUARD_EN
    #1;
    checks++; if (cpu_stall !== 1'b1) $display("FAIL t4_stall: got %b expected 1", cpu_stall); else passed++;
    tick("t4_collide");
    #1;
    checks++; if (ram[13'h040] !== 8'h44) $display("FAIL t4_dma_wins: got %h expected 44", ram[13'h040]); else passed++;
    checks++; if (cpu_stall !== 1'b0) $display("FAIL t4_retry_stall: got %b expected 0", cpu_stall); else passed++;
    tick("t4_retry");
    #1;
    checks++; if (ram[13'h040] !== 8'h33) $display("FAIL t4_cpu_retry: got %h expected 33", ram[13'h040]); else passed++;
`else
    tick("t4_cpu_first");
    #1;
    checks++; if (ram[13'h040] !== 8'h33) $display("FAIL t4_cpu_wins: got %h expected 33", ram[13'h040]); else passed++;
    cpu_we = 1'b0;
    tick("t4_dma_grant");
    #1;
    checks++; if (ram[13'h040] !== 8'h44) $display("FAIL t4_dma_after: got %h expected 44", ram[13'h040]); else passed++;
    tick("t4_ack");
`endif
    idle_inputs();
    tick("t4_idle");
  endtask

  task automatic test_reset_in_ack();
    cpu_write(13'h050, 8'h77);
    dma_req = 1'b1; dma_we = 1'b0; dma_a = 13'h050;
    tick("t5_grant");
    rst = 1'b1;
    #1;
    checks++; if (dma_ack !== 1'b1) $display("FAIL t5_ack_in_rst: got %b expected 1", dma_ack); else passed++;
    checks++; if (dma_r !== 8'h77) $display("FAIL t5_data: got %h expected 77", dma_r); else passed++;
    tick("t5_rst");
    rst = 1'b0;
    idle_inputs();
    #1;
    checks++; if (dma_ack !== 1'b0) $display("FAIL t5_ack_after_rst: got %b expected 0", dma_ack); else passed++;
    checks++; if (dma_r !== 8'h00) $display("FAIL t5_dma_r_cleared: got %h expected 00", dma_r); else passed++;
    tick("t5_after");
    dma_req = 1'b1; dma_we = 1'b0; dma_a = 13'h050;
    tick("t5_regrant");
    #1;
    checks++; if (dma_ack !== 1'b1) $display("FAIL t5_idle_state: got %b expected 1", dma_ack); else passed++;
    tick("t5_ack");
    idle_inputs();
    tick("t5_idle");
  endtask

  task automatic test_back_to_back();
    bit prev_ack, was_ack;
    prev_ack = 1'b0;
    dma_req = 1'b1; dma_we = 1'($urandom_range(0, 1)); dma_a = AW'($urandom_range(0, 7)); dma_w = 8'($urandom);
    for (int i = 0; i < 12; i++) begin
      #1;
      checks++; if (dma_ack !== (i % 2 == 1)) $display("FAIL b2b_ack cycle %0d: got %b expected %b", i, dma_ack, i % 2 == 1); else passed++;
      checks++; if (prev_ack && dma_ack) $display("FAIL b2b_consecutive cycle %0d: got 1 expected 0", i); else passed++;
      prev_ack = dma_ack;
      was_ack = mdl_ack;
      tick("b2b");
      if (was_ack) begin
        dma_we = 1'($urandom_range(0, 1)); dma_a = AW'($urandom_range(0, 7)); dma_w = 8'($urandom);
      end
    end
    idle_inputs();
    tick("b2b_idle");
  endtask

  task automatic test_random();
    int r;
    bit hold, g, was_ack;
    hold = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!hold) begin
        r = $urandom_range(0, 4);
        cpu_we = (r == 1); cpu_re = (r >= 2 && r <= 3);
        cpu_a = AW'($urandom_range(0, 7)); cpu_w = 8'($urandom);
      end
      if (!dma_req && $urandom_range(0, 2) == 0) begin
        dma_req = 1'b1; dma_we = 1'($urandom_range(0, 1)); dma_a = AW'($urandom_range(0, 7)); dma_w = 8'($urandom);
      end
      g = mdl_grant();
      hold = GUARD && g && (cpu_we || cpu_re);
      was_ack = mdl_ack;
      tick("rand");
      if (was_ack) begin
        if ($urandom_range(0, 1) == 1) begin
          dma_we = 1'($urandom_range(0, 1)); dma_a = AW'($urandom_range(0, 7)); dma_w = 8'($urandom);
        end else begin
          dma_req = 1'b0;
        end
      end
    end
    idle_inputs();
    tick("rand_drain");
    tick("rand_drain");
    for (int a = 0; a < 8; a++) begin
      checks++; if (ram[a] !== mdl_mem[a]) $display("FAIL rand_mem[%0d]: got %h expected %h", a, ram[a], mdl_mem[a]); else passed++;
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i] <= 8'h00;
      mdl_mem[i] = 8'h00;
    end
    mdl_ack = 1'b0; mdl_wait = 0; mdl_dma_r = 8'h00;
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_dma_write_read();
    test_starve();
    test_collision();
    test_reset_in_ack();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
